load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1: pipeline presents a memory request.
REQ-004 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3: RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
REQ-007 SHALL have port req_addr, input, 32: byte address from the ALU.
REQ-008 SHALL have port req_wdata, input, 32: store data from rs2.
REQ-009 SHALL have port resp_valid, output, 1: response available.
REQ-010 SHALL have port resp_ready, input, 1: pipeline consumes the response.
REQ-011 SHALL have port resp_rdata, output, 32: extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_error, output, 1: misaligned access or illegal funct3.
REQ-013 SHALL have port mem_address, output, 32: word-aligned address to data memory.
REQ-014 SHALL have port mem_write_data, output, 32: full word to data memory.
REQ-015 SHALL have port MemWrite, output, 1: data-memory write enable (synchronous write).
REQ-016 SHALL have port MemRead, output, 1: data-memory read enable.
REQ-017 SHALL have port mem_read_data, input, 32: combinational read word from data memory.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, RMW_READ, WRITE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready, latching write, funct3, addr and wdata.
REQ-020 On accept, the FSM SHALL go to RESP with resp_error=1 if funct3 is illegal, or if the access is misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0). No memory strobe SHALL be issued.
REQ-021 A legal load SHALL go to LOAD. In LOAD: MemRead=1 and mem_address={addr[31:2],2'b00}; mem_read_data is registered at the end of the cycle; next state is RESP.
REQ-022 A legal SW SHALL go to WRITE with mem_write_data=wdata.
REQ-023 A legal SB/SH SHALL go to RMW_READ. There, MemRead=1 and the old word is captured. In the following WRITE cycle, the old word is driven with the addressed lane replaced: SB replaces byte addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0].
REQ-024 In WRITE, MemWrite SHALL be 1 for exactly one cycle with the same mem_address; next state is RESP.
REQ-025 Latency from accept to resp_valid SHALL be: error 1 cycle, load 2 cycles, SW 2 cycles, SB/SH 3 cycles.
REQ-026 Load extraction SHALL select byte addr[1:0] or half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-027 In RESP, resp_valid=1 and resp_rdata/resp_error SHALL be held stable until resp_ready=1. Then the FSM returns to IDLE, with no back-to-back accept in the same cycle.
REQ-028 MemRead and MemWrite SHALL never both be 1. Both SHALL be 0 in IDLE and RESP. mem_address and mem_write_data SHALL be 0 outside LOAD, RMW_READ and WRITE.

Reset
REQ-029 While reset_n=0, the FSM SHALL be IDLE. Outputs: req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, MemRead=0, MemWrite=0, mem_address=0, mem_write_data=0.
REQ-030 Reset asserted mid-operation, including in WRITE, SHALL deassert MemWrite immediately (asynchronously) and drop the pending request and response.

Verification
REQ-031 Memory word at 0x40 = 0x8899AABB, LB at addr 0x41 -> MemRead in cycle 1; resp_valid in cycle 2 with resp_rdata=0xFFFFFFAA, resp_error=0.
REQ-032 Same word, LHU at addr 0x42 -> resp_rdata=0x00008899; LH at 0x42 -> 0xFFFF8899.
REQ-033 Word at 0x40 = 0x11223344, SB addr 0x42 wdata 0xDEADBEEF -> RMW_READ, then one MemWrite cycle with mem_write_data=0x11EF3344; resp_valid at cycle 3 with resp_rdata=0; a subsequent LW at 0x40 returns 0x11EF3344.
REQ-034 SW at addr 0x46 -> resp_error=1 at cycle 1; MemRead and MemWrite never asserted; memory unchanged.
REQ-035 LW with resp_ready held 0 for 4 cycles -> resp_valid, resp_rdata and req_ready=0 stable for all 4 cycles; IDLE one cycle after resp_ready=1.
REQ-036 SH issued, reset_n pulled low during the WRITE cycle before the clock edge -> MemWrite drops at once, memory unchanged, all outputs take their reset values, and the next request is processed normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32 load/store unit: byte/half/word loads and stores against a single-port
// word memory; sub-word stores are done as read-modify-write.
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    req_illegal = 1'b0;
    if (req_write) begin
      req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    req_misaligned = 1'b0;
    if (req_funct3[1:0] == 2'b01) req_misaligned = req_addr[0];
    if (req_funct3[1:0] == 2'b10) req_misaligned = (req_addr[1:0] != 2'b00);
    req_err = req_illegal || req_misaligned;
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = mem_read_data >> {addr_q[1:0], 3'b000};
    load_ext = mem_read_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // wword_q still holds the store data here; splice its low lane into the old word.
  always_comb begin
    merged = mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wword_q[7:0];
        2'd1:    merged[15:8]  = wword_q[7:0];
        2'd2:    merged[23:16] = wword_q[7:0];
        default: merged[31:24] = wword_q[7:0];
      endcase
    end else begin
      if (addr_q[1]) merged[31:16] = wword_q[15:0];
      else           merged[15:0]  = wword_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = RESP;
          else if (!req_write)          state_d = LOAD;
          else if (req_funct3 == 3'b010) state_d = WRITE;
          else                          state_d = RMW_READ;
        end
      end
      LOAD:     state_d = RESP;
      RMW_READ: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     if (resp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    MemRead        = (state_q == LOAD) || (state_q == RMW_READ);
    MemWrite       = (state_q == WRITE);
    mem_address    = '0;
    mem_write_data = '0;
    resp_valid     = (state_q == RESP);
    resp_rdata     = '0;
    resp_error     = 1'b0;
    if (MemRead || MemWrite) mem_address = {addr_q[31:2], 2'b00};
    if (MemWrite) mem_write_data = wword_q;
    if (resp_valid) begin
      resp_rdata = rdata_q;
      resp_error = error_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wword_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wword_q  <= req_wdata;
            rdata_q  <= '0;
            error_q  <= req_err;
          end
        end
        LOAD:     rdata_q <= write_q ? '0 : load_ext;
        RMW_READ: wword_q <= merged;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_read_data;

  int checks   = 0;
  int failures = 0;
  int writes   = 0;

  logic [31:0] mem [0:63];

  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (MemWrite) begin
      mem[mem_address[7:2]] <= mem_write_data;
      writes <= writes + 1;
    end
  end

  load_store_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .MemWrite       (MemWrite),
    .MemRead        (MemRead),
    .mem_read_data  (mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_strobes"},    {30'd0, MemRead, MemWrite}, 32'd0);
    chk({tag, "_mem_addr"},   mem_address, 32'd0);
    chk({tag, "_mem_wdata"},  mem_write_data, 32'd0);
  endtask

  // Present a request at a negedge; it is accepted on the following posedge.
  // Returns at the negedge of cycle 1 after accept.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    chk("pre_accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
  endtask

  // Called while in RESP at a negedge; completes the handshake and checks IDLE.
  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_c1_memread"}, {30'd0, MemRead, MemWrite}, 32'd2);
    chk({tag, "_c1_addr"}, mem_address, {a[31:2], 2'b00});
    chk({tag, "_c1_valid"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clock);
    chk({tag, "_c2_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_c2_rdata"}, resp_rdata, exp);
    chk({tag, "_c2_error"}, {31'd0, resp_error}, 32'd0);
    chk({tag, "_c2_strobes"}, {30'd0, MemRead, MemWrite}, 32'd0);
    consume(tag);
  endtask

  task automatic do_error(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a);
    int w0;
    w0 = writes;
    issue(w, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_error"}, {31'd0, resp_error}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_strobes"}, {30'd0, MemRead, MemWrite}, 32'd0);
    consume(tag);
    chk({tag, "_no_write"}, writes - w0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h8899AABB;
    mem[17] = 32'hCAFEF00D;

    repeat (2) @(negedge clock);
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    do_load("lb_41",  3'b000, 32'h41, 32'hFFFFFFAA);
    do_load("lhu_42", 3'b101, 32'h42, 32'h00008899);
    do_load("lh_42",  3'b001, 32'h42, 32'hFFFF8899);
    do_load("lbu_40", 3'b100, 32'h40, 32'h000000BB);
    do_load("lw_40",  3'b010, 32'h40, 32'h8899AABB);

    // SB read-modify-write, 3-cycle latency
    mem[16] = 32'h11223344;
    issue(1'b1, 3'b000, 32'h42, 32'hDEADBEEF);
    chk("sb_c1_strobes", {30'd0, MemRead, MemWrite}, 32'd2);
    chk("sb_c1_addr", mem_address, 32'h40);
    @(negedge clock);
    chk("sb_c2_strobes", {30'd0, MemRead, MemWrite}, 32'd1);
    chk("sb_c2_addr", mem_address, 32'h40);
    chk("sb_c2_wdata", mem_write_data, 32'h11EF3344);
    chk("sb_c2_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clock);
    chk("sb_c3_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_c3_rdata", resp_rdata, 32'd0);
    chk("sb_c3_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    consume("sb");
    do_load("lw_after_sb", 3'b010, 32'h40, 32'h11EF3344);

    // SH low half
    issue(1'b1, 3'b001, 32'h40, 32'h12345678);
    @(negedge clock);
    chk("sh_c2_wdata", mem_write_data, 32'h11EF5678);
    @(negedge clock);
    chk("sh_c3_valid", {31'd0, resp_valid}, 32'd1);
    consume("sh");

    // SW, 2-cycle latency
    issue(1'b1, 3'b010, 32'h48, 32'hA5A5A5A5);
    chk("sw_c1_strobes", {30'd0, MemRead, MemWrite}, 32'd1);
    chk("sw_c1_wdata", mem_write_data, 32'hA5A5A5A5);
    chk("sw_c1_addr", mem_address, 32'h48);
    @(negedge clock);
    chk("sw_c2_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw_c2_error", {31'd0, resp_error}, 32'd0);
    consume("sw");
    do_load("lw_48", 3'b010, 32'h48, 32'hA5A5A5A5);

    // Error cases: misaligned and illegal funct3
    do_error("sw_46", 1'b1, 3'b010, 32'h46);
    chk("sw_46_mem", mem[17], 32'hCAFEF00D);
    do_error("sh_41", 1'b1, 3'b001, 32'h41);
    do_error("lw_42", 1'b0, 3'b010, 32'h42);
    do_error("lhu_43", 1'b0, 3'b101, 32'h43);
    do_error("ld_f3_011", 1'b0, 3'b011, 32'h40);
    do_error("st_f3_100", 1'b1, 3'b100, 32'h40);
    chk("err_mem16", mem[16], 32'h11EF5678);

    // LW held in RESP for 4 cycles
    issue(1'b0, 3'b010, 32'h44, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'hCAFEF00D);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    consume("hold");

    // Reset during the WRITE cycle of an SH
    issue(1'b1, 3'b001, 32'h42, 32'h0000FFFF);
    @(negedge clock);
    chk("rst_write_active", {30'd0, MemRead, MemWrite}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
    chk_reset_outputs("rst_async");
    @(negedge clock);
    chk_reset_outputs("rst_held");
    chk("rst_mem_unchanged", mem[16], 32'h11EF5678);
    reset_n = 1'b1;
    do_load("lw_after_rst", 3'b010, 32'h40, 32'h11EF5678);
    do_load("lb_after_rst", 3'b000, 32'h43, 32'h00000011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
